fir_stream: RTL and testbench

FIR_STREAM -- requirements
Module: fir_stream

---
 rtl/fir_stream.sv | 138 +++++++++++++
 tb/tb_fir_stream.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream.sv
// Streaming FIR filter: shift-register sample window and coefficient chain,
// one multiply-accumulate per cycle, then round, shift and saturate to DW bits.
module fir_stream #(
    parameter int N_TAPS = 16,
    parameter int DW     = 16,
    parameter int CW     = 16,
    parameter int SHIFT  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wind,
    input  logic                 load,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] data,
    output logic                 out_valid,
    output logic signed [DW-1:0] out,
    output logic                 busy,
    output logic                 sat
);

    localparam int LW = $clog2(N_TAPS);
    localparam int PW = DW + CW;
    localparam int AW = PW + LW;
    localparam int IW = LW;
    localparam int unsigned RS = (SHIFT > 0) ? SHIFT - 1 : 0;

    // Rounding constant and saturation limits, one bit wider than acc so the
    // rounding add cannot wrap.
    localparam logic signed [AW:0] RND  = (SHIFT > 0) ? ({{AW{1'b0}}, 1'b1} << RS) : '0;
    localparam logic signed [AW:0] MAXV = {{(AW + 2 - DW){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [AW:0] MINV = {{(AW + 2 - DW){1'b1}}, {(DW - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t               state;
    logic signed [DW-1:0] x [N_TAPS];
    logic signed [CW-1:0] c [N_TAPS];
    logic [IW-1:0]        idx;
    logic signed [AW-1:0] acc;

    logic signed [CW-1:0] coef_in;
    logic signed [DW-1:0] x_sel;
    logic signed [CW-1:0] c_sel;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] prod_ext;
    logic signed [AW:0]   rnd_sum;
    logic signed [AW:0]   shifted;
    logic                 sat_hi;
    logic                 sat_lo;
    logic signed [DW-1:0] res;

    generate
        if (CW <= DW) begin : g_coef_trunc
            assign coef_in = data[CW-1:0];
        end else begin : g_coef_ext
            assign coef_in = {{(CW - DW){data[DW-1]}}, data};
        end
    endgenerate

    always_comb begin
        x_sel    = x[idx];
        c_sel    = c[idx];
        prod     = $signed({{CW{x_sel[DW-1]}}, x_sel}) * $signed({{DW{c_sel[CW-1]}}, c_sel});
        prod_ext = {{LW{prod[PW-1]}}, prod};
    end

    always_comb begin
        rnd_sum = {acc[AW-1], acc} + RND;
        shifted = rnd_sum >>> SHIFT;
        sat_hi  = shifted > MAXV;
        sat_lo  = shifted < MINV;
        if (sat_hi) begin
            res = MAXV[DW-1:0];
        end else if (sat_lo) begin
            res = MINV[DW-1:0];
        end else begin
            res = shifted[DW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            idx       <= '0;
            out       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            for (int unsigned i = 0; i < N_TAPS; i++) begin
                x[i] <= '0;
                c[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // A start request takes precedence over any chain shift.
                    if (in_valid) begin
                        acc   <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= MAC;
                    end else begin
                        if (wind) begin
                            x[0] <= data;
                            for (int unsigned i = 1; i < N_TAPS; i++) begin
                                x[i] <= x[i-1];
                            end
                        end
                        if (load) begin
                            c[0] <= coef_in;
                            for (int unsigned i = 1; i < N_TAPS; i++) begin
                                c[i] <= c[i-1];
                            end
                        end
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    idx <= idx + 1'b1;
                    if (idx == IW'(N_TAPS - 1)) begin
                        state <= OUT;
                    end
                end
                OUT: begin
                    out       <= res;
                    sat       <= sat_hi | sat_lo;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_stream.sv
// Bench for fir_stream: a 16-tap unshifted instance (a) and a 4-tap SHIFT=4
// instance (b), driven from a vector table and hand sequences, checked by a scoreboard.
module tb_fir_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic               rst_a = 1'b0, wind_a = 1'b0, load_a = 1'b0, iv_a = 1'b0;
    logic signed [15:0] data_a = '0;
    logic               ov_a, busy_a, sat_a;
    logic signed [15:0] out_a;

    logic               rst_b = 1'b0, wind_b = 1'b0, load_b = 1'b0, iv_b = 1'b0;
    logic signed [15:0] data_b = '0;
    logic               ov_b, busy_b, sat_b;
    logic signed [15:0] out_b;

    fir_stream #(.N_TAPS(16), .DW(16), .CW(16), .SHIFT(0)) u_a (
        .clk(clk), .rst(rst_a), .wind(wind_a), .load(load_a), .in_valid(iv_a),
        .data(data_a), .out_valid(ov_a), .out(out_a), .busy(busy_a), .sat(sat_a)
    );

    fir_stream #(.N_TAPS(4), .DW(16), .CW(16), .SHIFT(4)) u_b (
        .clk(clk), .rst(rst_b), .wind(wind_b), .load(load_b), .in_valid(iv_b),
        .data(data_b), .out_valid(ov_b), .out(out_b), .busy(busy_b), .sat(sat_b)
    );

    typedef struct { int out; bit sat; int due; } exp_t;
    typedef struct { int sel; int xp; int cp; int eo; bit es; } vec_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   errors = 0;
    int   checks = 0;
    int   xm[2][64];
    int   cm[2][64];
    int   due_last[2];
    bit   ovr = 1'b0;
    int   ovr_out;
    bit   ovr_sat;
    vec_t vt[17];

    function automatic int ntaps(input int s);
        return (s != 0) ? 4 : 16;
    endfunction

    function automatic int shamt(input int s);
        return (s != 0) ? 4 : 0;
    endfunction

    function automatic int sx16(input int d);
        logic signed [15:0] t;
        t = d[15:0];
        return int'(t);
    endfunction

    function automatic void compute(input int s, output int o, output bit st);
        longint acc = 0;
        for (int i = 0; i < ntaps(s); i++) acc += longint'(xm[s][i]) * longint'(cm[s][i]);
        if (shamt(s) > 0) acc += longint'(1) << (shamt(s) - 1);
        acc = acc >>> shamt(s);
        if (acc > 32767) begin
            o = 32767; st = 1'b1;
        end else if (acc < -32768) begin
            o = -32768; st = 1'b1;
        end else begin
            o = int'(acc); st = 1'b0;
        end
    endfunction

    function automatic int pat(input int p, input int k, input int n);
        case (p)
            0:  return k + 1;
            1:  return 32767;
            2:  return -32768;
            3:  return (k == n - 1) ? 8 : 0;
            4:  return (k == n - 1) ? -8 : 0;
            5:  return (k == n - 1) ? 1 : 0;
            6:  return 1;
            7:  return -(k + 1);
            8:  return (k == n - 1) ? 3 : 0;
            9:  return (k == n - 1) ? 32767 : 0;
            10: return (k == n - 1) ? -32768 : 0;
            11: return (k == n - 2) ? 1 : ((k == n - 1) ? 32767 : 0);
            12: return (k == n - 2) ? -1 : ((k == n - 1) ? -32768 : 0);
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic int qsize(input int s);
        return (s != 0) ? q_b.size() : q_a.size();
    endfunction

    // Model of the input side; edge e is the next rising edge to sample inputs.
    task automatic model_apply(input int s, input bit w, input bit l, input bit v, input int d);
        int   e = cyc + 1;
        int   n = ntaps(s);
        exp_t t;
        if (e <= due_last[s]) return;
        if (v) begin
            if (ovr) begin
                t.out = ovr_out; t.sat = ovr_sat; ovr = 1'b0;
            end else begin
                compute(s, t.out, t.sat);
            end
            t.due = e + n + 1;
            due_last[s] = t.due;
            if (s != 0) q_b.push_back(t); else q_a.push_back(t);
        end else begin
            if (w) begin
                for (int i = n - 1; i > 0; i--) xm[s][i] = xm[s][i-1];
                xm[s][0] = sx16(d);
            end
            if (l) begin
                for (int i = n - 1; i > 0; i--) cm[s][i] = cm[s][i-1];
                cm[s][0] = sx16(d);
            end
        end
    endtask

    task automatic step(input int s, input bit w, input bit l, input bit v, input int d);
        @(posedge clk);
        #2;
        rst_a = 1'b0; rst_b = 1'b0;
        wind_a = (s == 0) && w; load_a = (s == 0) && l; iv_a = (s == 0) && v;
        wind_b = (s != 0) && w; load_b = (s != 0) && l; iv_b = (s != 0) && v;
        data_a = d[15:0]; data_b = d[15:0];
        model_apply(s, w, l, v, d);
    endtask

    task automatic do_reset(input int s);
        @(posedge clk);
        #2;
        wind_a = 1'b0; load_a = 1'b0; iv_a = 1'b0;
        wind_b = 1'b0; load_b = 1'b0; iv_b = 1'b0;
        rst_a = (s == 0); rst_b = (s != 0);
        for (int i = 0; i < 64; i++) begin
            xm[s][i] = 0; cm[s][i] = 0;
        end
        if (s != 0) q_b.delete(); else q_a.delete();
        due_last[s] = 0;
    endtask

    task automatic drain(input int s);
        for (int i = 0; i < 60; i++) begin
            if (qsize(s) == 0) break;
            step(s, 1'b0, 1'b0, 1'b0, 0);
        end
        chk((s != 0) ? "b_pending_results" : "a_pending_results", qsize(s), 0);
        if (s != 0) q_b.delete(); else q_a.delete();
    endtask

    task automatic mon(input int s);
        string pre = (s != 0) ? "b" : "a";
        bit    ov  = (s != 0) ? ov_b : ov_a;
        bit    bz  = (s != 0) ? busy_b : busy_a;
        bit    st  = (s != 0) ? sat_b : sat_a;
        int    o   = (s != 0) ? int'(out_b) : int'(out_a);
        exp_t  t;
        if (ov) begin
            checks++;
            if (qsize(s) == 0) begin
                errors++;
                $display("FAIL %s_unexpected_pulse: got out_valid=1 at cycle %0d, want 0", pre, cyc);
            end else begin
                t = (s != 0) ? q_b.pop_front() : q_a.pop_front();
                chk({pre, "_out"}, o, t.out);
                chk({pre, "_sat"}, int'(st), int'(t.sat));
                chk({pre, "_latency_cycle"}, cyc, t.due);
                chk({pre, "_busy_at_pulse"}, int'(bz), 0);
            end
        end else if (qsize(s) > 0) begin
            t = (s != 0) ? q_b[0] : q_a[0];
            if (cyc > t.due) begin
                checks++;
                errors++;
                $display("FAIL %s_missing_pulse: got no out_valid by cycle %0d, want one at %0d", pre, cyc, t.due);
                if (s != 0) void'(q_b.pop_front()); else void'(q_a.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout at cycle %0d, want completion", cyc);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        vt[0]  = '{0, 0,  0,  1496,   1'b0};
        vt[1]  = '{0, 1,  1,  32767,  1'b1};
        vt[2]  = '{0, 2,  1,  -32768, 1'b1};
        vt[3]  = '{0, 2,  2,  32767,  1'b1};
        vt[4]  = '{0, 7,  0,  -1496,  1'b0};
        vt[5]  = '{0, 0,  6,  136,    1'b0};
        vt[6]  = '{0, 9,  5,  32767,  1'b0};
        vt[7]  = '{0, 10, 5,  -32768, 1'b0};
        vt[8]  = '{0, 11, 6,  32767,  1'b1};
        vt[9]  = '{0, 12, 6,  -32768, 1'b1};
        vt[10] = '{1, 3,  5,  1,      1'b0};
        vt[11] = '{1, 4,  5,  0,      1'b0};
        vt[12] = '{1, 0,  0,  2,      1'b0};
        vt[13] = '{1, 3,  8,  2,      1'b0};
        vt[14] = '{1, 4,  8,  -1,     1'b0};
        vt[15] = '{1, 1,  1,  32767,  1'b1};
        vt[16] = '{1, 2,  1,  -32768, 1'b1};

        due_last[0] = 0;
        due_last[1] = 0;
        do_reset(0);
        do_reset(1);
        step(0, 1'b0, 1'b0, 1'b0, 0);
        chk("a_reset_out", int'(out_a), 0);
        chk("a_reset_sat", int'(sat_a), 0);
        chk("a_reset_busy", int'(busy_a), 0);
        chk("a_reset_out_valid", int'(ov_a), 0);
        chk("b_reset_out", int'(out_b), 0);
        chk("b_reset_busy", int'(busy_b), 0);

        foreach (vt[v]) begin
            n = ntaps(vt[v].sel);
            for (int k = 0; k < n; k++) step(vt[v].sel, 1'b1, 1'b0, 1'b0, pat(vt[v].xp, k, n));
            for (int k = 0; k < n; k++) step(vt[v].sel, 1'b0, 1'b1, 1'b0, pat(vt[v].cp, k, n));
            ovr = 1'b1; ovr_out = vt[v].eo; ovr_sat = vt[v].es;
            step(vt[v].sel, 1'b0, 1'b0, 1'b1, 0);
            drain(vt[v].sel);
            step(vt[v].sel, 1'b0, 1'b0, 1'b0, 0);
            step(vt[v].sel, 1'b0, 1'b0, 1'b0, 0);
            chk($sformatf("vec%0d_held_out", v), (vt[v].sel != 0) ? int'(out_b) : int'(out_a), vt[v].eo);
        end

        // wind+load together shift both chains; a start cycle ignores wind/load
        for (int k = 0; k < 4; k++) step(1, 1'b1, 1'b1, 1'b0, k + 1);
        step(1, 1'b1, 1'b1, 1'b1, 1000);
        step(1, 1'b0, 1'b0, 1'b0, 0);
        chk("b_busy_in_mac", int'(busy_b), 1);
        drain(1);
        step(1, 1'b0, 1'b0, 1'b1, 0);
        drain(1);

        // requests during a computation are ignored and chains stay frozen
        for (int k = 0; k < 16; k++) step(0, 1'b1, 1'b0, 1'b0, k + 1);
        for (int k = 0; k < 16; k++) step(0, 1'b0, 1'b1, 1'b0, k + 1);
        step(0, 1'b0, 1'b0, 1'b1, 0);
        for (int k = 0; k < 6; k++) begin
            step(0, 1'b1, 1'b1, 1'b1, 99);
            chk("a_busy_in_mac", int'(busy_a), 1);
        end
        drain(0);
        step(0, 1'b0, 1'b0, 1'b1, 0);
        drain(0);

        // reset sampled on edge 5 of a computation aborts it and clears chains
        step(0, 1'b0, 1'b0, 1'b1, 0);
        for (int k = 0; k < 3; k++) step(0, 1'b0, 1'b0, 1'b0, 0);
        do_reset(0);
        step(0, 1'b0, 1'b0, 1'b0, 0);
        chk("a_abort_busy", int'(busy_a), 0);
        chk("a_abort_out", int'(out_a), 0);
        chk("a_abort_sat", int'(sat_a), 0);
        chk("a_abort_out_valid", int'(ov_a), 0);
        for (int k = 0; k < 20; k++) step(0, 1'b0, 1'b0, 1'b0, 0);
        step(0, 1'b0, 1'b0, 1'b1, 0);
        drain(0);

        step(0, 1'b0, 1'b0, 1'b0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
